regbank_mp: RTL and testbench
=============================

# regbank_mp

Parametrised multi-port register bank with a registered read path, byte-strobed writes, write-to-read bypass, and a per-register pending-write scoreboard. It is the next-generation register file for the SPI processor core. The CPU datapath drives one write port and READ_PORTS read ports. The issue stage marks registers whose results are still in flight and stalls on the per-port ready flag.

## Interface
- REG_WIDTH, 32: register width in bits; must be a multiple of 8.
- REG_COUNT, 16: number of registers; ≥2; need not be a power of two.
- READ_PORTS, 2: number of independent read ports; ≥1.
- ZERO_REG, 1: when 1, register 0 is hardwired to zero.
- BYPASS, 1: when 1, a same-cycle write is forwarded to a matching read.
- AW (local): $clog2(REG_COUNT).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  REG_WIDTH  write data.
- wstrb  in  REG_WIDTH/8  byte enables; bit b covers wdata[8b+7:8b].
- mark_en  in  1  set the pending bit of mark_addr.
- mark_addr  in  AW  register whose result is now in flight.
- raddr  in  READ_PORTS*AW  read addresses; port i is raddr[i*AW +: AW].
- rdata  out  READ_PORTS*REG_WIDTH  read data; port i is rdata[i*REG_WIDTH +: REG_WIDTH].
- rready  out  READ_PORTS  1 means rdata for port i is architecturally valid (not pending).

## Operation
- Storage: REG_COUNT×REG_WIDTH flops plus REG_COUNT pending bits.
- Write: when we=1 and waddr<REG_COUNT, each byte whose wstrb bit is 1 is updated; other bytes are kept. The pending bit of waddr is cleared. The clear applies even if wstrb is 0.
- Ignored writes:
  - ZERO_REG=1 with waddr=0: ignored.
  - waddr≥REG_COUNT: ignored, no side effects.
- Mark: when mark_en=1 and mark_addr<REG_COUNT, the pending bit of mark_addr is set.
  - Ignored for mark_addr=0 when ZERO_REG=1.
  - Ignored for out-of-range mark_addr.
- Simultaneous mark and write to the same address: mark wins and the pending bit ends at 1. The data write still happens.
- Read, per port, registered:
  - rdata_i ← contents of raddr_i as seen after this cycle's write (see bypass).
  - rready_i ← NOT (pending bit of raddr_i after this cycle's write/mark update).
- Bypass:
  - BYPASS=1 and we=1 and waddr==raddr_i (write not ignored): captured rdata_i is the old value merged with the strobed wdata bytes.
  - BYPASS=0: captured rdata_i is the old value, but the register itself still updates.
- Special read addresses:
  - ZERO_REG=1, raddr_i=0: rdata_i=0, rready_i=1.
  - raddr_i≥REG_COUNT: rdata_i=0, rready_i=1.
- Read ports are fully independent; any number may address the same register.
- No state machine beyond the storage and pending bits. All ports are usable every cycle; there is no back-pressure.

## Timing
- Reset (rst=1 at an edge):
  - All registers are set to 0 and all pending bits are cleared.
  - rdata=0, rready=0 on every port.
  - we and mark_en are ignored in that cycle.
- First post-reset edge with rst=0: rready_i=1 for all ports.
- Read latency: 1 cycle. The address presented at edge N gives rdata/rready valid after edge N.
- Write-to-storage latency: 1 cycle.
  - With BYPASS=1, a read issued in the same cycle sees the new data after the same edge.
  - With BYPASS=0, the new data is seen one cycle later.
- Mark-to-ready:
  - A read issued in the mark cycle returns rready=0.
  - The write that clears the bit makes a same-cycle read return rready=1, independent of BYPASS.
- Reset mid-operation: a write or mark coinciding with rst is discarded.

## Test plan
- Reset then read: hold rst=1 for 2 cycles with we=1, waddr=3, wdata=0xFFFFFFFF; release and read r3 on both ports -> rdata=0x00000000, rready=1.
- Byte strobe: write r5=0x11223344 with wstrb=0xF; next cycle write wdata=0xAABBCCDD with wstrb=0x5; read r5 -> 0x11BB33DD.
- Bypass: BYPASS=1; in one cycle write r7=0xDEADBEEF and read r7 on port 0 and r2 on port 1 -> after the edge, port 0 = 0xDEADBEEF and port 1 = old r2. Repeat with BYPASS=0 -> port 0 returns the old r7 value, and the following read returns 0xDEADBEEF.
- Scoreboard: mark r4 and read r4 -> rready=0; hold 3 cycles -> rready stays 0; write r4=0x12 while reading r4 -> rready=1, rdata=0x12. Mark and write r4 in the same cycle -> pending stays set (rready=0 next read).
- Zero and range: ZERO_REG=1, write r0=0x55 and mark r0 -> r0 reads 0, rready=1. REG_COUNT=12: write to address 14 -> no register changes; read address 14 -> 0, rready=1.
- Port independence: READ_PORTS=4, write distinct values 0x10..0x13 to r8..r11, then read all four ports in one cycle -> each port returns its own value; all ports on r9 -> all return 0x11.

Source files
------------

// File: rtl/regbank_mp.sv
// Multi-port register bank: byte-strobed write port, READ_PORTS registered read ports, per-register pending scoreboard.
// Latency: 1 cycle from address to rdata/rready; write visible same edge with BYPASS=1, next cycle with BYPASS=0.
// Backpressure: none; every port accepts a request every cycle, rready only reports architectural validity.
module regbank_mp #(
    parameter int REG_WIDTH  = 32,
    parameter int REG_COUNT  = 16,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we,
    input  logic [AW-1:0]                    waddr,
    input  logic [REG_WIDTH-1:0]             wdata,
    input  logic [REG_WIDTH/8-1:0]           wstrb,
    input  logic                             mark_en,
    input  logic [AW-1:0]                    mark_addr,
    input  logic [READ_PORTS*AW-1:0]         raddr,
    output logic [READ_PORTS*REG_WIDTH-1:0]  rdata,
    output logic [READ_PORTS-1:0]            rready
);

    localparam int        NB = REG_WIDTH / 8;
    // Register count widened by one bit so the range check also works when REG_COUNT is a power of two.
    localparam logic [AW:0] RC = (AW + 1)'(REG_COUNT);

    logic [REG_WIDTH-1:0] regs_q [REG_COUNT];
    logic [REG_WIDTH-1:0] regs_d [REG_COUNT];
    logic [REG_COUNT-1:0] pend_q;
    logic [REG_COUNT-1:0] pend_d;
    logic                 wr_ok;
    logic                 mark_ok;
    logic [REG_WIDTH-1:0] rd_d   [READ_PORTS];
    logic [READ_PORTS-1:0] rr_d;

    // A write/mark only takes effect for an in-range address that is not the hardwired zero register.
    assign wr_ok   = we && ({1'b0, waddr} < RC) && !((ZERO_REG != 0) && (waddr == '0));
    assign mark_ok = mark_en && ({1'b0, mark_addr} < RC) && !((ZERO_REG != 0) && (mark_addr == '0));

    // Next-state storage and scoreboard: write merges strobed bytes and clears pending, mark sets it last so it wins.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int r = 0; r < REG_COUNT; r++) begin
            if (wr_ok && (waddr == AW'(r))) begin
                for (int b = 0; b < NB; b++) begin
                    if (wstrb[b]) begin
                        regs_d[r][8*b +: 8] = wdata[8*b +: 8];
                    end
                end
                pend_d[r] = 1'b0;
            end
            if (mark_ok && (mark_addr == AW'(r))) begin
                pend_d[r] = 1'b1;
            end
        end
    end

    // Per-port read select; zero register and out-of-range addresses return 0 and are always ready.
    always_comb begin
        for (int p = 0; p < READ_PORTS; p++) begin
            rd_d[p] = '0;
            rr_d[p] = 1'b1;
            for (int r = 0; r < REG_COUNT; r++) begin
                if ((raddr[p*AW +: AW] == AW'(r)) && !((ZERO_REG != 0) && (r == 0))) begin
                    rd_d[p] = (BYPASS != 0) ? regs_d[r] : regs_q[r];
                    // Readiness always reflects this cycle's write/mark, regardless of data bypass.
                    rr_d[p] = !pend_d[r];
                end
            end
        end
    end

    // State and registered read outputs; reset discards any coincident write or mark.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                regs_q[r] <= '0;
            end
            pend_q <= '0;
            rdata  <= '0;
            rready <= '0;
        end else begin
            for (int r = 0; r < REG_COUNT; r++) begin
                regs_q[r] <= regs_d[r];
            end
            pend_q <= pend_d;
            for (int p = 0; p < READ_PORTS; p++) begin
                rdata[p*REG_WIDTH +: REG_WIDTH] <= rd_d[p];
            end
            rready <= rr_d;
        end
    end

endmodule

// File: tb/tb_regbank_mp.sv
// Directed bench for regbank_mp: bypass/no-bypass 2-port instances plus a 12-register 4-port instance.
// Latency: each vector is applied, one rising edge passes, outputs are sampled 1 time unit later.
// Backpressure: not applicable; stimulus is driven every cycle.
module tb_regbank_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        mark_en;
    logic [3:0]  mark_addr;
    logic [7:0]  raddr_ab;
    logic [15:0] raddr_c;
    logic [63:0] rdata_a;
    logic [1:0]  rready_a;
    logic [63:0] rdata_b;
    logic [1:0]  rready_b;
    logic [127:0] rdata_c;
    logic [3:0]  rready_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regbank_mp #(.REG_WIDTH(32), .REG_COUNT(16), .READ_PORTS(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .mark_en(mark_en), .mark_addr(mark_addr), .raddr(raddr_ab), .rdata(rdata_a), .rready(rready_a));

    regbank_mp #(.REG_WIDTH(32), .REG_COUNT(16), .READ_PORTS(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .mark_en(mark_en), .mark_addr(mark_addr), .raddr(raddr_ab), .rdata(rdata_b), .rready(rready_b));

    regbank_mp #(.REG_WIDTH(32), .REG_COUNT(12), .READ_PORTS(4), .ZERO_REG(1), .BYPASS(1)) dut_c (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .mark_en(mark_en), .mark_addr(mark_addr), .raddr(raddr_c), .rdata(rdata_c), .rready(rready_c));

    typedef struct {
        logic        rst;
        logic        we;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        mk;
        logic [3:0]  maddr;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [31:0] ad0;
        logic [31:0] ad1;
        logic [31:0] bd0;
        logic [31:0] bd1;
        logic        r0;
        logic        r1;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    function automatic vec_t mk(logic r, logic w, logic [3:0] wa, logic [31:0] wd, logic [3:0] ws,
                                logic m, logic [3:0] ma, logic [3:0] a0, logic [3:0] a1,
                                logic [31:0] ad0, logic [31:0] ad1, logic [31:0] bd0, logic [31:0] bd1,
                                logic r0, logic r1);
        vec_t v;
        v.rst = r; v.we = w; v.waddr = wa; v.wdata = wd; v.wstrb = ws; v.mk = m; v.maddr = ma;
        v.ra0 = a0; v.ra1 = a1; v.ad0 = ad0; v.ad1 = ad1; v.bd0 = bd0; v.bd1 = bd1; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drv(input logic w, input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                       input logic m, input logic [3:0] ma);
        we = w; waddr = wa; wdata = wd; wstrb = ws; mark_en = m; mark_addr = ma;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_c(input string name, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3, input logic [3:0] er);
        chk({name, " c.d0"}, rdata_c[31:0],   e0);
        chk({name, " c.d1"}, rdata_c[63:32],  e1);
        chk({name, " c.d2"}, rdata_c[95:64],  e2);
        chk({name, " c.d3"}, rdata_c[127:96], e3);
        chk({name, " c.rdy"}, {28'd0, rready_c}, {28'd0, er});
    endtask

    initial begin
        rst = 1'b1; raddr_ab = '0; raddr_c = '0;
        drv(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);

        //              rst we wa  wdata          ws    mk ma  ra0 ra1 a_d0           a_d1           b_d0           b_d1           r0 r1
        tbl[0]  = mk(1, 1, 3, 32'hFFFFFFFF, 4'hF, 0, 0, 3, 3, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
        tbl[1]  = mk(1, 1, 3, 32'hFFFFFFFF, 4'hF, 0, 0, 3, 3, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
        tbl[2]  = mk(0, 0, 0, 32'h0,        4'h0, 0, 0, 3, 3, 32'h0,        32'h0,        32'h0,        32'h0,        1, 1);
        tbl[3]  = mk(0, 1, 5, 32'h11223344, 4'hF, 0, 0, 5, 2, 32'h11223344, 32'h0,        32'h0,        32'h0,        1, 1);
        tbl[4]  = mk(0, 1, 5, 32'hAABBCCDD, 4'h5, 0, 0, 5, 5, 32'h11BB33DD, 32'h11BB33DD, 32'h11223344, 32'h11223344, 1, 1);
        tbl[5]  = mk(0, 0, 0, 32'h0,        4'h0, 0, 0, 5, 5, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 1, 1);
        tbl[6]  = mk(0, 1, 2, 32'h22222222, 4'hF, 0, 0, 2, 5, 32'h22222222, 32'h11BB33DD, 32'h0,        32'h11BB33DD, 1, 1);
        tbl[7]  = mk(0, 1, 7, 32'hDEADBEEF, 4'hF, 0, 0, 7, 2, 32'hDEADBEEF, 32'h22222222, 32'h0,        32'h22222222, 1, 1);
        tbl[8]  = mk(0, 0, 0, 32'h0,        4'h0, 0, 0, 7, 7, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1);
        tbl[9]  = mk(0, 0, 0, 32'h0,        4'h0, 1, 4, 4, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 1);
        tbl[10] = mk(0, 0, 0, 32'h0,        4'h0, 0, 0, 4, 4, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
        tbl[11] = mk(0, 0, 0, 32'h0,        4'h0, 0, 0, 4, 4, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
        tbl[12] = mk(0, 0, 0, 32'h0,        4'h0, 0, 0, 4, 4, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
        tbl[13] = mk(0, 1, 4, 32'h12,       4'hF, 0, 0, 4, 4, 32'h12,       32'h12,       32'h0,        32'h0,        1, 1);
        tbl[14] = mk(0, 1, 4, 32'h34,       4'hF, 1, 4, 4, 5, 32'h34,       32'h11BB33DD, 32'h12,       32'h11BB33DD, 0, 1);
        tbl[15] = mk(0, 0, 0, 32'h0,        4'h0, 0, 0, 4, 4, 32'h34,       32'h34,       32'h34,       32'h34,       0, 0);
        tbl[16] = mk(0, 1, 4, 32'hFF,       4'h0, 0, 0, 4, 4, 32'h34,       32'h34,       32'h34,       32'h34,       1, 1);
        tbl[17] = mk(0, 1, 0, 32'h55,       4'hF, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        1, 1);
        tbl[18] = mk(0, 0, 0, 32'h0,        4'h0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        1, 1);
        tbl[19] = mk(1, 1, 5, 32'hFFFFFFFF, 4'hF, 1, 6, 5, 6, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
        tbl[20] = mk(0, 0, 0, 32'h0,        4'h0, 0, 0, 5, 6, 32'h0,        32'h0,        32'h0,        32'h0,        1, 1);
        tbl[21] = mk(0, 0, 0, 32'h0,        4'h0, 0, 0, 7, 4, 32'h0,        32'h0,        32'h0,        32'h0,        1, 1);

        @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].rst;
            drv(tbl[i].we, tbl[i].waddr, tbl[i].wdata, tbl[i].wstrb, tbl[i].mk, tbl[i].maddr);
            raddr_ab = {tbl[i].ra1, tbl[i].ra0};
            cyc();
            chk($sformatf("v%0d a.d0", i), rdata_a[31:0],  tbl[i].ad0);
            chk($sformatf("v%0d a.d1", i), rdata_a[63:32], tbl[i].ad1);
            chk($sformatf("v%0d b.d0", i), rdata_b[31:0],  tbl[i].bd0);
            chk($sformatf("v%0d b.d1", i), rdata_b[63:32], tbl[i].bd1);
            chk($sformatf("v%0d a.rdy", i), {30'd0, rready_a}, {30'd0, tbl[i].r1, tbl[i].r0});
            chk($sformatf("v%0d b.rdy", i), {30'd0, rready_b}, {30'd0, tbl[i].r1, tbl[i].r0});
        end

        // 12-register 4-port instance: fill r8..r11 with 0x10..0x13.
        raddr_c = '0;
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 4'(8 + i), 32'h10 + i, 4'hF, 1'b0, 4'd0);
            cyc();
        end
        drv(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
        raddr_c = {4'd11, 4'd10, 4'd9, 4'd8};
        cyc();
        chk_c("ports own", 32'h10, 32'h11, 32'h12, 32'h13, 4'hF);

        raddr_c = {4'd9, 4'd9, 4'd9, 4'd9};
        cyc();
        chk_c("ports r9", 32'h11, 32'h11, 32'h11, 32'h11, 4'hF);

        // Out-of-range write and mark at address 14, read back out-of-range in the same cycle.
        drv(1'b1, 4'd14, 32'h99, 4'hF, 1'b1, 4'd14);
        raddr_c = {4'd14, 4'd14, 4'd14, 4'd14};
        cyc();
        chk_c("oor read", 32'h0, 32'h0, 32'h0, 32'h0, 4'hF);

        drv(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
        raddr_c = {4'd11, 4'd10, 4'd9, 4'd8};
        cyc();
        chk_c("oor no alias hi", 32'h10, 32'h11, 32'h12, 32'h13, 4'hF);

        raddr_c = {4'd12, 4'd14, 4'd6, 4'd2};
        cyc();
        chk_c("oor no alias lo", 32'h0, 32'h0, 32'h0, 32'h0, 4'hF);

        // Independent readiness: r9 pending, other ports unaffected.
        drv(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd9);
        raddr_c = {4'd11, 4'd9, 4'd8, 4'd9};
        cyc();
        chk_c("mixed pend", 32'h11, 32'h10, 32'h11, 32'h13, 4'b1010);

        drv(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
